// File: rtl/event_sync_bank.sv
// event_sync_bank: per-channel synchroniser bank turning foreign-domain
// toggles/levels into one-clk strobes with sticky pending/overflow flags.
// Ports: clk, rst (sync, active-high); async_in, ack, clr_ovf (inputs);
// pulse_out, pending, overflow, any_pending, first_idx, miss_cnt (outputs).
module event_sync_bank #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 3,
    parameter int EDGE_MODE   = 0,
    parameter int CNT_W       = 8,
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] async_in,
    input  logic [CHANNELS-1:0] ack,
    input  logic                clr_ovf,
    output logic [CHANNELS-1:0] pulse_out,
    output logic [CHANNELS-1:0] pending,
    output logic [CHANNELS-1:0] overflow,
    output logic                any_pending,
    output logic [IDX_W-1:0]    first_idx,
    output logic [CNT_W-1:0]    miss_cnt
);

    localparam int SUM_W = CNT_W + 6;
    localparam logic [2:0] WARM_INIT = 3'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0] MISS_MAX = '1;

    logic [SYNC_STAGES-1:0] syncQ [CHANNELS];
    logic [CHANNELS-1:0]    histQ;
    logic [CHANNELS-1:0]    syncLast;
    logic [CHANNELS-1:0]    rawEvt;
    logic [CHANNELS-1:0]    evt;
    logic [CHANNELS-1:0]    lost;
    logic [2:0]             warmCnt;
    logic                   warmDone;
    logic [SUM_W-1:0]       lostCnt;
    logic [SUM_W-1:0]       missSum;
    logic [CNT_W-1:0]       missNext;

    // Synchroniser chains, edge history and warm-up counter. The warm-up
    // window covers the chain depth plus the history flop, so whatever
    // level is present at reset release never looks like an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                syncQ[i] <= '0;
            end
            histQ   <= '0;
            warmCnt <= WARM_INIT;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                syncQ[i] <= {syncQ[i][SYNC_STAGES-2:0], async_in[i]};
            end
            histQ <= syncLast;
            if (warmCnt != 3'd0) begin
                warmCnt <= warmCnt - 3'd1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            syncLast[i] = syncQ[i][SYNC_STAGES-1];
        end
    end

    generate
        if (EDGE_MODE == 0) begin : gAny
            assign rawEvt = syncLast ^ histQ;
        end else if (EDGE_MODE == 1) begin : gRise
            assign rawEvt = syncLast & ~histQ;
        end else begin : gFall
            assign rawEvt = ~syncLast & histQ;
        end
    endgenerate

    assign warmDone = (warmCnt == 3'd0);
    assign evt      = warmDone ? rawEvt : '0;
    // An ack in the same cycle as an event absorbs the older event,
    // so only an un-acked pending flag turns a new event into a loss.
    assign lost     = evt & pending & ~ack;

    // Saturating miss counter; clr_ovf zeroes the base, not the
    // increment, so losses in the clearing cycle are still counted.
    always_comb begin
        lostCnt = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            lostCnt = lostCnt + SUM_W'(lost[i]);
        end
        missSum = (clr_ovf ? '0 : SUM_W'(miss_cnt)) + lostCnt;
        if (missSum > SUM_W'(MISS_MAX)) begin
            missNext = MISS_MAX;
        end else begin
            missNext = missSum[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_out <= '0;
            pending   <= '0;
            overflow  <= '0;
            miss_cnt  <= '0;
        end else begin
            pulse_out <= evt;
            pending   <= evt | (pending & ~ack);
            overflow  <= (clr_ovf ? '0 : overflow) | lost;
            miss_cnt  <= missNext;
        end
    end

    assign any_pending = |pending;

    // Scan downwards so the lowest set index is the last one written.
    always_comb begin
        first_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (pending[i]) begin
                first_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: tb/tb_event_sync_bank.sv
// tb_event_sync_bank: three instances (any/rise/fall edge modes) driven
// with shared stimulus and compared against a sample-history model.
module tb_event_sync_bank;

    localparam int S = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] asyncIn;
    logic [3:0] ack;
    logic       clrOvf;

    logic [3:0] pulseO [3];
    logic [3:0] pendO  [3];
    logic [3:0] ovfO   [3];
    logic       anyO   [3];
    logic [1:0] idxO   [3];
    logic [7:0] miss0;
    logic [3:0] miss1;
    logic [7:0] miss2;
    logic [7:0] missO  [3];

    always #5 clk = ~clk;

    always_comb begin
        missO[0] = miss0;
        missO[1] = {4'b0, miss1};
        missO[2] = miss2;
    end

    event_sync_bank #(.EDGE_MODE(0)) dut0 (
        .clk(clk), .rst(rst), .async_in(asyncIn), .ack(ack),
        .clr_ovf(clrOvf), .pulse_out(pulseO[0]), .pending(pendO[0]),
        .overflow(ovfO[0]), .any_pending(anyO[0]),
        .first_idx(idxO[0]), .miss_cnt(miss0));

    event_sync_bank #(.EDGE_MODE(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .async_in(asyncIn), .ack(ack),
        .clr_ovf(clrOvf), .pulse_out(pulseO[1]), .pending(pendO[1]),
        .overflow(ovfO[1]), .any_pending(anyO[1]),
        .first_idx(idxO[1]), .miss_cnt(miss1));

    event_sync_bank #(.EDGE_MODE(2)) dut2 (
        .clk(clk), .rst(rst), .async_in(asyncIn), .ack(ack),
        .clr_ovf(clrOvf), .pulse_out(pulseO[2]), .pending(pendO[2]),
        .overflow(ovfO[2]), .any_pending(anyO[2]),
        .first_idx(idxO[2]), .miss_cnt(miss2));

    int checks = 0;
    int errors = 0;

    // Model: input value sampled at each edge since reset. An event seen
    // after edge e compares the samples from edges e-S and e-S-1, and
    // nothing is reported before edge S+2 (warm-up).
    logic [3:0] samp [$];
    int         edges;
    int         modeOf  [3] = '{0, 1, 2};
    int         missMax [3] = '{255, 15, 255};
    logic [3:0] expPulse [3];
    logic [3:0] expPend  [3];
    logic [3:0] expOvf   [3];
    int         expMiss  [3];

    function automatic logic [1:0] firstOf(input logic [3:0] p);
        for (int i = 0; i < 4; i++) begin
            if (p[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    task automatic step();
        logic [3:0] cur, prv, evt, lst;
        int base;
        @(posedge clk);
        if (rst) begin
            samp.delete();
            edges = 0;
            for (int m = 0; m < 3; m++) begin
                expPulse[m] = '0;
                expPend[m]  = '0;
                expOvf[m]   = '0;
                expMiss[m]  = 0;
            end
        end else begin
            samp.push_back(asyncIn);
            edges++;
            for (int m = 0; m < 3; m++) begin
                evt = '0;
                if (edges >= S + 2) begin
                    cur = samp[edges-1-S];
                    prv = samp[edges-2-S];
                    case (modeOf[m])
                        0:       evt = cur ^ prv;
                        1:       evt = cur & ~prv;
                        default: evt = ~cur & prv;
                    endcase
                end
                lst  = evt & expPend[m] & ~ack;
                base = clrOvf ? 0 : expMiss[m];
                base += $countones(lst);
                expMiss[m]  = (base > missMax[m]) ? missMax[m] : base;
                expOvf[m]   = (clrOvf ? 4'h0 : expOvf[m]) | lst;
                expPend[m]  = evt | (expPend[m] & ~ack);
                expPulse[m] = evt;
            end
        end
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        ack    = '0;
        clrOvf = 1'b0;
        rst    = 1'b1;
        steps(2);
        rst    = 1'b0;
    endtask

    task automatic test_reset();
        asyncIn = '0;
        do_reset();
        for (int m = 0; m < 3; m++) begin
            checks++;
            if ({pulseO[m], pendO[m], ovfO[m]} !== 12'h0) begin
                errors++;
                $display("FAIL reset_flags inst %0d got %h exp 000", m,
                         {pulseO[m], pendO[m], ovfO[m]});
            end
            checks++;
            if (missO[m] !== 8'h0 || anyO[m] !== 1'b0 || idxO[m] !== 2'd0) begin
                errors++;
                $display("FAIL reset_cnt inst %0d got miss %0d any %b idx %0d exp 0",
                         m, missO[m], anyO[m], idxO[m]);
            end
        end
    endtask

    task automatic test_warmup_high();
        asyncIn = 4'hF;
        do_reset();
        repeat (20) begin
            step();
            for (int m = 0; m < 3; m++) begin
                checks++;
                if ({pulseO[m], pendO[m]} !== 8'h0) begin
                    errors++;
                    $display("FAIL warm_high inst %0d got %h exp 00", m,
                             {pulseO[m], pendO[m]});
                end
            end
        end
    endtask

    task automatic test_latency();
        asyncIn = '0;
        do_reset();
        steps(S + 3);
        #8;
        asyncIn[0] = 1'b1;
        step();
        for (int j = 1; j <= 3; j++) begin
            checks++;
            if (pulseO[0][0] !== 1'b0) begin
                errors++;
                $display("FAIL lat_early edge k+%0d got 1 exp 0", j - 1);
            end
            step();
        end
        checks++;
        if (pulseO[0][0] !== 1'b1 || pendO[0][0] !== 1'b1) begin
            errors++;
            $display("FAIL lat_pulse got pulse %b pend %b exp 1 1",
                     pulseO[0][0], pendO[0][0]);
        end
        checks++;
        if (idxO[0] !== 2'd0 || anyO[0] !== 1'b1) begin
            errors++;
            $display("FAIL lat_idx got idx %0d any %b exp 0 1", idxO[0], anyO[0]);
        end
        checks++;
        if (pulseO[1][0] !== 1'b1 || pulseO[2][0] !== 1'b0) begin
            errors++;
            $display("FAIL lat_modes got rise %b fall %b exp 1 0",
                     pulseO[1][0], pulseO[2][0]);
        end
        step();
        checks++;
        if (pulseO[0][0] !== 1'b0 || pendO[0][0] !== 1'b1) begin
            errors++;
            $display("FAIL lat_once got pulse %b pend %b exp 0 1",
                     pulseO[0][0], pendO[0][0]);
        end
    endtask

    task automatic test_edge_modes();
        int riseCnt [3];
        int fallCnt [3];
        int expRise [3] = '{1, 1, 0};
        int expFall [3] = '{1, 0, 1};
        asyncIn = '0;
        do_reset();
        steps(S + 3);
        for (int m = 0; m < 3; m++) begin
            riseCnt[m] = 0;
            fallCnt[m] = 0;
        end
        asyncIn[2] = 1'b1;
        repeat (10) begin
            step();
            for (int m = 0; m < 3; m++) riseCnt[m] += int'(pulseO[m][2]);
        end
        asyncIn[2] = 1'b0;
        repeat (10) begin
            step();
            for (int m = 0; m < 3; m++) fallCnt[m] += int'(pulseO[m][2]);
        end
        for (int m = 0; m < 3; m++) begin
            checks++;
            if (riseCnt[m] != expRise[m] || fallCnt[m] != expFall[m]) begin
                errors++;
                $display("FAIL edge_mode inst %0d got rise %0d fall %0d exp %0d %0d",
                         m, riseCnt[m], fallCnt[m], expRise[m], expFall[m]);
            end
        end
    endtask

    task automatic test_overflow();
        asyncIn = '0;
        do_reset();
        steps(S + 3);
        repeat (3) begin
            asyncIn[1] = ~asyncIn[1];
            steps(5);
        end
        steps(5);
        checks++;
        if (pendO[0][1] !== 1'b1 || ovfO[0][1] !== 1'b1 || missO[0] !== 8'd2) begin
            errors++;
            $display("FAIL ovf_set got pend %b ovf %b miss %0d exp 1 1 2",
                     pendO[0][1], ovfO[0][1], missO[0]);
        end
        checks++;
        if (missO[1] !== 8'(expMiss[1]) || expMiss[1] != 1) begin
            errors++;
            $display("FAIL ovf_rise got miss %0d exp 1", missO[1]);
        end
        clrOvf = 1'b1;
        step();
        clrOvf = 1'b0;
        checks++;
        if (ovfO[0] !== 4'h0 || missO[0] !== 8'd0 || pendO[0][1] !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clr got ovf %h miss %0d pend %b exp 0 0 1",
                     ovfO[0], missO[0], pendO[0][1]);
        end
    endtask

    task automatic test_ack_collide();
        asyncIn = '0;
        do_reset();
        steps(S + 3);
        asyncIn[3] = 1'b1;
        steps(6);
        asyncIn[3] = 1'b0;
        steps(3);
        ack[3] = 1'b1;
        step();
        ack[3] = 1'b0;
        checks++;
        if (pulseO[0][3] !== 1'b1 || pendO[0][3] !== 1'b1) begin
            errors++;
            $display("FAIL ack_evt got pulse %b pend %b exp 1 1",
                     pulseO[0][3], pendO[0][3]);
        end
        checks++;
        if (ovfO[0][3] !== 1'b0 || missO[0] !== 8'd0) begin
            errors++;
            $display("FAIL ack_noovf got ovf %b miss %0d exp 0 0",
                     ovfO[0][3], missO[0]);
        end
        step();
        checks++;
        if (pendO[0][3] !== 1'b1 || idxO[0] !== 2'd3) begin
            errors++;
            $display("FAIL ack_hold got pend %b idx %0d exp 1 3",
                     pendO[0][3], idxO[0]);
        end
    endtask

    task automatic test_saturation();
        asyncIn = '0;
        do_reset();
        steps(S + 3);
        repeat (42) begin
            asyncIn[0] = ~asyncIn[0];
            steps(2);
        end
        steps(6);
        checks++;
        if (missO[1] !== 8'd15 || missO[0] !== 8'd41 || missO[2] !== 8'd20) begin
            errors++;
            $display("FAIL sat_cnt got %0d %0d %0d exp 41 15 20",
                     missO[0], missO[1], missO[2]);
        end
        steps(5);
        checks++;
        if (missO[1] !== 8'd15 || ovfO[1][0] !== 1'b1) begin
            errors++;
            $display("FAIL sat_hold got miss %0d ovf %b exp 15 1",
                     missO[1], ovfO[1][0]);
        end
    endtask

    task automatic test_reset_mid();
        asyncIn = '0;
        do_reset();
        steps(S + 3);
        asyncIn = 4'b1010;
        steps(6);
        checks++;
        if (pendO[0] !== 4'b1010 || idxO[0] !== 2'd1) begin
            errors++;
            $display("FAIL mid_pend got %b idx %0d exp 1010 1", pendO[0], idxO[0]);
        end
        asyncIn[2] = 1'b1;
        rst = 1'b1;
        step();
        checks++;
        if ({pulseO[0], pendO[0], ovfO[0]} !== 12'h0 || missO[0] !== 8'd0 ||
            anyO[0] !== 1'b0 || idxO[0] !== 2'd0) begin
            errors++;
            $display("FAIL mid_rst got %h miss %0d any %b idx %0d exp all 0",
                     {pulseO[0], pendO[0], ovfO[0]}, missO[0], anyO[0], idxO[0]);
        end
        rst = 1'b0;
        repeat (10) begin
            step();
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (pulseO[m] !== 4'h0) begin
                    errors++;
                    $display("FAIL mid_quiet inst %0d got %h exp 0", m, pulseO[m]);
                end
            end
        end
    endtask

    task automatic test_random();
        asyncIn = 4'($urandom);
        do_reset();
        repeat (600) begin
            rst    = ($urandom_range(0, 99) == 0);
            asyncIn = asyncIn ^ (4'($urandom) & 4'($urandom));
            ack    = 4'($urandom) & 4'($urandom);
            clrOvf = ($urandom_range(0, 15) == 0);
            step();
            for (int m = 0; m < 3; m++) begin
                checks++;
                if (pulseO[m] !== expPulse[m] || pendO[m] !== expPend[m]) begin
                    errors++;
                    $display("FAIL rnd_pp inst %0d got %h %h exp %h %h", m,
                             pulseO[m], pendO[m], expPulse[m], expPend[m]);
                end
                checks++;
                if (ovfO[m] !== expOvf[m] || missO[m] !== 8'(expMiss[m])) begin
                    errors++;
                    $display("FAIL rnd_ovf inst %0d got %h %0d exp %h %0d", m,
                             ovfO[m], missO[m], expOvf[m], expMiss[m]);
                end
                checks++;
                if (anyO[m] !== (|expPend[m]) || idxO[m] !== firstOf(expPend[m])) begin
                    errors++;
                    $display("FAIL rnd_idx inst %0d got %b %0d exp %b %0d", m,
                             anyO[m], idxO[m], |expPend[m], firstOf(expPend[m]));
                end
            end
        end
        rst    = 1'b0;
        ack    = '0;
        clrOvf = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        asyncIn = '0;
        ack     = '0;
        clrOvf  = 1'b0;
        test_reset();
        test_warmup_high();
        test_latency();
        test_edge_modes();
        test_overflow();
        test_ack_collide();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/event_sync_bank.md
EVENT_SYNC_BANK -- requirements
Module: event_sync_bank

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent event channels, range 1..32.
REQ-002 Parameter SYNC_STAGES, default 3: synchroniser flops per channel, range 2..4.
REQ-003 Parameter EDGE_MODE, default 0: event detection; 0 = any edge (toggle protocol), 1 = rising only, 2 = falling only.
REQ-004 Parameter CNT_W, default 8: width of the missed-event counter, range 4..16.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset; synchronous, active-high.
REQ-007 async_in  input  CHANNELS  per-channel toggle/level from a foreign domain; not related to clk.
REQ-008 ack  input  CHANNELS  per-channel pending-flag clear, sampled on clk.
REQ-009 clr_ovf  input  1  clears all overflow flags and miss_cnt.
REQ-010 pulse_out  output  CHANNELS  one-clk event strobe per channel, registered.
REQ-011 pending  output  CHANNELS  sticky event flag per channel, registered.
REQ-012 overflow  output  CHANNELS  sticky flag: event arrived while pending, registered.
REQ-013 any_pending  output  1  OR of pending.
REQ-014 first_idx  output  max(1,clog2(CHANNELS))  lowest index with pending=1; 0 when none.
REQ-015 miss_cnt  output  CNT_W  saturating count of lost events, registered.

Function
REQ-016 Per channel: chain sync[0..SYNC_STAGES-1], sync[0] samples async_in[i]; hist[i] <= sync[SYNC_STAGES-1] every cycle.
REQ-017 raw_evt[i] from sync[last] vs hist[i]: mode 0 differ; mode 1 sync=1,hist=0; mode 2 sync=0,hist=1.
REQ-018 Warm-up: warm_cnt loads SYNC_STAGES+1 on reset, decrements each cycle to 0, holds 0; evt[i] = raw_evt[i] AND warm_cnt==0.
REQ-019 pulse_out[i] <= evt[i]; input change settled before edge k gives pulse_out high exactly for the cycle after edge k+SYNC_STAGES.
REQ-020 A single input transition never produces more than one pulse_out cycle; input transitions closer than 1 clk may merge (mode 0: even count of toggles within one sample is lost by design).
REQ-021 pending[i] next: 1 if evt[i]; else 0 if ack[i]; else hold. Event and ack same cycle: pending stays 1, no overflow.
REQ-022 Overflow: evt[i] AND pending[i]=1 AND ack[i]=0 sets overflow[i] and counts as a lost event.
REQ-023 miss_cnt <= min(miss_cnt + number of channels losing an event this cycle, 2^CNT_W-1); saturates, never wraps.
REQ-024 clr_ovf=1: overflow and miss_cnt cleared that edge; a lost event the same cycle wins (overflow[i]=1, miss_cnt=its increment from 0).
REQ-025 any_pending and first_idx combinational from registered pending; first_idx = lowest set index.
REQ-026 ack on a channel not pending: no effect. Multiple simultaneous channel events handled independently.

Reset
REQ-027 rst=1 at edge: sync, hist, pulse_out, pending, overflow, miss_cnt cleared to 0; warm_cnt=SYNC_STAGES+1.
REQ-028 Reset mid-operation discards in-flight events and pending flags; no pulse_out during rst or warm-up.
REQ-029 Input held high across reset release (mode 0/1) produces no event; first event is the next transition after warm-up.

Verification
REQ-030 Defaults; rise async_in[0] 1 ns before edge k after warm-up -> pulse_out[0]=1 only after edge k+3, pending[0]=1 from same edge, first_idx=0.
REQ-031 EDGE_MODE=1; async_in[2] 0->1->0 with 10 clk spacing -> one pulse on rise only; EDGE_MODE=2 -> pulse on fall only.
REQ-032 Channel 1 pending, two more toggles, no ack -> overflow[1]=1, miss_cnt=2; clr_ovf -> both 0, pending[1] still 1.
REQ-033 Event and ack[3] same cycle -> pending[3] stays 1, overflow[3]=0; CNT_W=4, 20 lost events -> miss_cnt=15 held.
REQ-034 async_in=4'hF held through rst release -> no pulse_out, pending=0 for 20 clk; assert rst with pending=4'b1010 -> all outputs 0 next cycle.
